// File: rtl/pc_pipe_unit_if.sv
// ----------------------------------------------------------------------------
// pc_pipe_unit_if
//   Control and status bundle between the fetch controller and the PC unit.
//   master : drives the control requests (stall, halt, redirect, trap) and
//            observes the PC outputs.
//   slave  : the PC unit itself.
//   Signals
//     stall          hold PC and pipeline
//     halt_req       request to stop fetching
//     redirect_valid branch/jump taken, target on redirect_pc
//     trap_valid     exception/trap request
//     pc_o           registered fetch PC
//     pc_next_o      value pc_o takes at the next edge
//     pc_pipe_o      flattened PC shadow stages, stage k at [k*ADDR_W +: ADDR_W]
//     pc_valid_o     per-stage valid
//     misalign_o     one-cycle pulse on a misaligned redirect
//     state_o        0=BOOT, 1=RUN, 2=HALT
// ----------------------------------------------------------------------------
interface pc_pipe_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 2
);
    logic                      stall;
    logic                      halt_req;
    logic                      redirect_valid;
    logic [ADDR_W-1:0]         redirect_pc;
    logic                      trap_valid;
    logic [ADDR_W-1:0]         pc_o;
    logic [ADDR_W-1:0]         pc_next_o;
    logic [DEPTH*ADDR_W-1:0]   pc_pipe_o;
    logic [DEPTH-1:0]          pc_valid_o;
    logic                      misalign_o;
    logic [1:0]                state_o;

    modport master (
        output stall, halt_req, redirect_valid, redirect_pc, trap_valid,
        input  pc_o, pc_next_o, pc_pipe_o, pc_valid_o, misalign_o, state_o
    );

    modport slave (
        input  stall, halt_req, redirect_valid, redirect_pc, trap_valid,
        output pc_o, pc_next_o, pc_pipe_o, pc_valid_o, misalign_o, state_o
    );
endinterface

// File: rtl/pc_pipe_unit.sv
// ----------------------------------------------------------------------------
// pc_pipe_unit
//   Program-counter generator with a PC shadow pipeline of DEPTH stages.
//   After reset the unit sits in BOOT for BOOT_CYCLES cycles, then fetches
//   sequentially in RUN. Trap and redirect flush the shadow valids; halt stops
//   the PC and lets the pipeline drain with bubbles.
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous reset, active low
//     bus   pc_pipe_unit_if.slave (control requests in, PC/status out)
// ----------------------------------------------------------------------------

// One shadow stage: captures its input on shift, drops its valid on flush.
module pc_pipe_stage #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              vld_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              vld_o
);
    logic [ADDR_W-1:0] pc_q;
    logic              vld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            if (shift_i) pc_q <= pc_i;
            // flush and shift are mutually exclusive; flush keeps the value
            if (flush_i)      vld_q <= 1'b0;
            else if (shift_i) vld_q <= vld_i;
        end
    end

    assign pc_o  = pc_q;
    assign vld_o = vld_q;
endmodule

module pc_pipe_unit #(
    parameter int                ADDR_W      = 16,
    parameter int                INST_BYTES  = 2,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'(16'h0100),
    parameter int                DEPTH       = 2,
    parameter int                BOOT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    pc_pipe_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Low address bits that must be zero for an aligned instruction.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);

    state_e            state_q, state_d;
    logic [3:0]        boot_cnt_q, boot_cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;

    // pipeline controls
    logic              shift;
    logic              flush;
    logic              push_vld;

    logic [DEPTH-1:0][ADDR_W-1:0] stage_pc;
    logic [DEPTH-1:0]             vld_pipe;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        shift      = 1'b0;
        flush      = 1'b0;
        push_vld   = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                // Every request is ignored while booting.
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (int'(boot_cnt_q) + 1 >= BOOT_CYCLES) state_d = ST_RUN;
            end
            ST_RUN, ST_HALT: begin
                if (bus.trap_valid) begin
                    pc_d    = TRAP_VEC;
                    flush   = 1'b1;
                    state_d = ST_RUN;
                end else if (bus.redirect_valid) begin
                    pc_d       = bus.redirect_pc & ~ALIGN_MASK;
                    misalign_d = |(bus.redirect_pc & ALIGN_MASK);
                    flush      = 1'b1;
                    state_d    = ST_RUN;
                end else if (bus.stall) begin
                    // full hold; halt_req is not looked at
                end else if (state_q == ST_HALT) begin
                    shift = 1'b1;          // bubble drains the pipe
                end else if (bus.halt_req) begin
                    state_d = ST_HALT;
                    shift   = 1'b1;        // bubble, PC holds
                end else begin
                    pc_d     = pc_q + PC_INC;
                    shift    = 1'b1;
                    push_vld = 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow pipeline
    // ------------------------------------------------------------------
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [ADDR_W-1:0] in_pc;
        logic              in_vld;
        if (k == 0) begin : g_head
            assign in_pc  = pc_q;
            assign in_vld = push_vld;
        end else begin : g_tail
            assign in_pc  = stage_pc[k-1];
            assign in_vld = vld_pipe[k-1];
        end
        pc_pipe_stage #(.ADDR_W(ADDR_W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .shift_i (shift),
            .flush_i (flush),
            .pc_i    (in_pc),
            .vld_i   (in_vld),
            .pc_o    (stage_pc[k]),
            .vld_o   (vld_pipe[k])
        );
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pc_o       = pc_q;
    assign bus.pc_next_o  = pc_d;
    assign bus.pc_pipe_o  = stage_pc;   // packed layout already matches
    assign bus.pc_valid_o = vld_pipe;
    assign bus.misalign_o = misalign_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_pc_pipe_unit.sv
`timescale 1ns/1ps
module tb_pc_pipe_unit;
    logic clk = 1'b0;
    logic rst;
    logic rst8;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // default configuration
    pc_pipe_unit_if #(.ADDR_W(16), .DEPTH(2)) u_if ();
    pc_pipe_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    // narrow configuration: wrap, 4-byte alignment, no boot hold, 3 stages
    pc_pipe_unit_if #(.ADDR_W(8), .DEPTH(3)) u_if8 ();
    pc_pipe_unit #(
        .ADDR_W(8), .INST_BYTES(4), .RESET_VEC(8'h10), .TRAP_VEC(8'h40),
        .DEPTH(3), .BOOT_CYCLES(0)
    ) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (u_if8.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // sample 2ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        u_if.stall = 0; u_if.halt_req = 0; u_if.redirect_valid = 0;
        u_if.redirect_pc = '0; u_if.trap_valid = 0;
    endtask

    initial begin
        rst = 1'b0; rst8 = 1'b0;
        idle();
        u_if8.stall = 0; u_if8.halt_req = 0; u_if8.redirect_valid = 0;
        u_if8.redirect_pc = '0; u_if8.trap_valid = 0;

        // ---- reset state
        #12;
        chk("rst_pc",    u_if.pc_o, 16'h0000);
        chk("rst_vld",   u_if.pc_valid_o, 2'b00);
        chk("rst_pipe",  u_if.pc_pipe_o, 32'h0);
        chk("rst_mis",   u_if.misalign_o, 1'b0);
        chk("rst_state", u_if.state_o, 2'd0);

        // ---- 1: boot hold then sequential fetch; a trap during boot is ignored
        rst = 1'b1;
        u_if.trap_valid = 1;
        #1;
        chk("boot_next", u_if.pc_next_o, 16'h0000);
        tick();
        chk("boot1_state", u_if.state_o, 2'd0);
        chk("boot1_pc",    u_if.pc_o, 16'h0000);
        chk("boot1_vld",   u_if.pc_valid_o, 2'b00);
        u_if.trap_valid = 0;
        tick();
        chk("run0_state", u_if.state_o, 2'd1);
        chk("run0_pc",    u_if.pc_o, 16'h0000);
        chk("run0_next",  u_if.pc_next_o, 16'h0002);
        tick();
        chk("run1_pc",  u_if.pc_o, 16'h0002);
        chk("run1_vld", u_if.pc_valid_o, 2'b01);
        chk("run1_s0",  u_if.pc_pipe_o[15:0], 16'h0000);
        tick();
        chk("run2_pc",  u_if.pc_o, 16'h0004);
        chk("run2_vld", u_if.pc_valid_o, 2'b11);
        chk("run2_s0",  u_if.pc_pipe_o[15:0], 16'h0002);
        chk("run2_s1",  u_if.pc_pipe_o[31:16], 16'h0000);

        // ---- 2: stall for three edges
        u_if.stall = 1;
        #1;
        chk("stall_next", u_if.pc_next_o, 16'h0004);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc",   u_if.pc_o, 16'h0004);
            chk("stall_pipe", u_if.pc_pipe_o, {16'h0000, 16'h0002});
            chk("stall_vld",  u_if.pc_valid_o, 2'b11);
        end
        u_if.stall = 0;
        tick();
        chk("resume_pc",   u_if.pc_o, 16'h0006);
        chk("resume_pipe", u_if.pc_pipe_o, {16'h0002, 16'h0004});

        // ---- 3: misaligned redirect with stall
        u_if.redirect_valid = 1; u_if.redirect_pc = 16'h0041; u_if.stall = 1;
        #1;
        chk("redir_next", u_if.pc_next_o, 16'h0040);
        tick();
        idle();
        chk("redir_pc",  u_if.pc_o, 16'h0040);
        chk("redir_mis", u_if.misalign_o, 1'b1);
        chk("redir_vld", u_if.pc_valid_o, 2'b00);
        tick();
        chk("redir1_pc",  u_if.pc_o, 16'h0042);
        chk("redir1_mis", u_if.misalign_o, 1'b0);
        chk("redir1_vld", u_if.pc_valid_o, 2'b01);
        chk("redir1_s0",  u_if.pc_pipe_o[15:0], 16'h0040);

        // ---- 4: trap beats redirect
        u_if.trap_valid = 1; u_if.redirect_valid = 1; u_if.redirect_pc = 16'h0200;
        tick();
        idle();
        chk("trap_pc",  u_if.pc_o, 16'h0100);
        chk("trap_vld", u_if.pc_valid_o, 2'b00);
        chk("trap_mis", u_if.misalign_o, 1'b0);
        tick();
        chk("trap1_pc", u_if.pc_o, 16'h0102);

        // ---- 5: halt at pc 8 with a full pipe
        u_if.redirect_valid = 1; u_if.redirect_pc = 16'h0004;
        tick();
        idle();
        tick();
        tick();
        chk("pre_halt_pc",  u_if.pc_o, 16'h0008);
        chk("pre_halt_vld", u_if.pc_valid_o, 2'b11);
        u_if.halt_req = 1;
        #1;
        chk("halt_next", u_if.pc_next_o, 16'h0008);
        tick();
        chk("halt_state", u_if.state_o, 2'd2);
        chk("halt_pc",    u_if.pc_o, 16'h0008);
        chk("halt_vld",   u_if.pc_valid_o, 2'b10);
        chk("halt_s1",    u_if.pc_pipe_o[31:16], 16'h0006);
        tick();
        chk("halt2_pc",  u_if.pc_o, 16'h0008);
        chk("halt2_vld", u_if.pc_valid_o, 2'b00);
        u_if.halt_req = 0; u_if.stall = 1;
        tick();
        chk("halt_stall_state", u_if.state_o, 2'd2);
        chk("halt_stall_pc",    u_if.pc_o, 16'h0008);
        u_if.stall = 0; u_if.redirect_valid = 1; u_if.redirect_pc = 16'h0020;
        #1;
        chk("unhalt_next", u_if.pc_next_o, 16'h0020);
        tick();
        idle();
        chk("unhalt_state", u_if.state_o, 2'd1);
        chk("unhalt_pc",    u_if.pc_o, 16'h0020);
        chk("unhalt_vld",   u_if.pc_valid_o, 2'b00);
        tick();
        chk("unhalt1_pc", u_if.pc_o, 16'h0022);

        // ---- 6b: asynchronous reset mid-stall
        tick();
        u_if.stall = 1;
        tick();
        rst = 1'b0;
        #1;
        chk("arst_pc",    u_if.pc_o, 16'h0000);
        chk("arst_vld",   u_if.pc_valid_o, 2'b00);
        chk("arst_state", u_if.state_o, 2'd0);
        idle();

        // ---- 6a: narrow instance, wrap at FC -> 00
        rst8 = 1'b1;
        tick();
        chk("n_state", u_if8.state_o, 2'd1);
        chk("n_pc",    u_if8.pc_o, 8'h10);
        u_if8.redirect_valid = 1; u_if8.redirect_pc = 8'hFE;
        #1;
        chk("n_redir_next", u_if8.pc_next_o, 8'hFC);
        tick();
        u_if8.redirect_valid = 0;
        chk("n_redir_pc",  u_if8.pc_o, 8'hFC);
        chk("n_redir_mis", u_if8.misalign_o, 1'b1);
        tick();
        chk("n_wrap_pc",  u_if8.pc_o, 8'h00);
        chk("n_wrap_vld", u_if8.pc_valid_o, 3'b001);
        chk("n_wrap_s0",  u_if8.pc_pipe_o[7:0], 8'hFC);
        chk("n_wrap_mis", u_if8.misalign_o, 1'b0);
        tick();
        chk("n_seq_pc",  u_if8.pc_o, 8'h04);
        chk("n_seq_vld", u_if8.pc_valid_o, 3'b011);
        chk("n_seq_s1",  u_if8.pc_pipe_o[15:8], 8'hFC);
        u_if8.trap_valid = 1;
        tick();
        u_if8.trap_valid = 0;
        chk("n_trap_pc",  u_if8.pc_o, 8'h40);
        chk("n_trap_vld", u_if8.pc_valid_o, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
